bist_ctrl: RTL and testbench

BIST_CTRL -- requirements
Module: bist_ctrl

---
 rtl/bist_pkg.sv | 31 +++
 rtl/bist_ctrl_if.sv | 20 ++
 rtl/bist_cnt.sv | 24 ++
 rtl/bist_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bist_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST sequencer.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RSTD  = 3'd1,
        APPLY = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } bist_state_e;

    localparam int         DEF_WIDTH      = 8;
    localparam int         DEF_NUM_VEC    = 16;
    localparam int         DEF_DUV_LAT    = 2;
    localparam int         DEF_RST_CYCLES = 2;
    localparam int         DEF_ERR_W      = 8;
    localparam logic [7:0] DEF_SEED       = 8'hA5;

    function automatic logic is_busy(bist_state_e s);
        return (s == RSTD) || (s == APPLY) || (s == WAIT) || (s == CHECK);
    endfunction

    // Counter width large enough to hold the longer of the two hold-off loads.
    function automatic int cnt_width(int a, int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/bist_ctrl_if.sv
// Stimulus/response link between the BIST controller and the device under test.
interface bist_ctrl_if import bist_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             duv_rst;
    logic [WIDTH-1:0] stim;
    logic             stim_valid;
    logic [WIDTH-1:0] duv_resp;
    logic [WIDTH-1:0] exp_resp;

    modport master (
        output duv_rst, stim, stim_valid,
        input  duv_resp, exp_resp
    );

    modport slave (
        input  duv_rst, stim, stim_valid,
        output duv_resp, exp_resp
    );
endinterface

// File: rtl/bist_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero.
module bist_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);
endmodule

// File: rtl/bist_ctrl.sv
// BIST run sequencer: resets the DUV, walks NUM_VEC stimulus vectors and tallies mismatches.
//
//   state | meaning
//   IDLE  | waiting for start, DUV reset released
//   RSTD  | DUV reset held for RST_CYCLES
//   APPLY | new stimulus presented, stim_valid strobe
//   WAIT  | DUV_LAT cycles of response latency
//   CHECK | compare duv_resp against exp_resp, advance vector
//   DONE  | run finished, results held until next start
module bist_ctrl import bist_pkg::*; #(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter int               NUM_VEC    = DEF_NUM_VEC,
    parameter int               DUV_LAT    = DEF_DUV_LAT,
    parameter int               RST_CYCLES = DEF_RST_CYCLES,
    parameter int               ERR_W      = DEF_ERR_W,
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEF_SEED),
    localparam int              IDX_W      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    bist_ctrl_if.master      duv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] errcount,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [IDX_W-1:0] vec_idx
);
    localparam int               CNT_W     = cnt_width(RST_CYCLES, DUV_LAT);
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DUV_LAT - 1);
    localparam logic [IDX_W-1:0] LAST_VEC  = IDX_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    bist_state_e      state_q, state_d;
    logic [IDX_W-1:0] vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] ferr_q, ferr_d;
    logic             seen_q, seen_d;
    logic [WIDTH-1:0] stim_q, stim_d;
    logic             duv_rst_q, stim_valid_q, busy_q, done_q, pass_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;
    logic             mismatch;

    assign mismatch = (duv.duv_resp != duv.exp_resp);

    bist_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        seen_d   = seen_q;
        stim_d   = stim_q;
        cnt_load = 1'b0;
        cnt_val  = '0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d    = '0;
                    err_d    = '0;
                    ferr_d   = '0;
                    seen_d   = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = RST_LOAD;
                    state_d  = RSTD;
                end
            end
            RSTD: begin
                if (cnt_tc) begin
                    stim_d  = SEED + WIDTH'(vec_q);
                    state_d = APPLY;
                end
            end
            APPLY: begin
                cnt_load = 1'b1;
                cnt_val  = WAIT_LOAD;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_tc) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!seen_q) begin
                        ferr_d = vec_q;
                        seen_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    stim_d  = SEED + WIDTH'(vec_d);
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including the compare of a CHECK cycle.
        if (abort && is_busy(state_q)) begin
            state_d  = IDLE;
            vec_d    = vec_q;
            err_d    = err_q;
            ferr_d   = ferr_q;
            seen_d   = seen_q;
            stim_d   = stim_q;
            cnt_load = 1'b0;
        end
    end

    // Outputs are registered from the next-state decode so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vec_q        <= '0;
            err_q        <= '0;
            ferr_q       <= '0;
            seen_q       <= 1'b0;
            stim_q       <= '0;
            duv_rst_q    <= 1'b1;
            stim_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            vec_q        <= vec_d;
            err_q        <= err_d;
            ferr_q       <= ferr_d;
            seen_q       <= seen_d;
            stim_q       <= stim_d;
            duv_rst_q    <= (state_d == RSTD);
            stim_valid_q <= (state_d == APPLY);
            busy_q       <= is_busy(state_d);
            done_q       <= (state_d == DONE);
            pass_q       <= (state_d == DONE) && (err_d == '0);
        end
    end

    assign duv.duv_rst    = duv_rst_q;
    assign duv.stim       = stim_q;
    assign duv.stim_valid = stim_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign errcount       = err_q;
    assign first_err_idx  = ferr_q;
    assign vec_idx        = vec_q;
endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: stimulus scoreboard plus run-level result checks.
module tb_bist_ctrl;
    import bist_pkg::*;

    localparam int         NV       = 16;
    localparam logic [7:0] TB_SEED  = 8'hA5;
    localparam int         RUN_LEN  = 2 + NV * 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    bist_ctrl_if #(.WIDTH(8)) dif0 ();
    bist_ctrl_if #(.WIDTH(8)) dif3 ();

    logic       busy, done, pass;
    logic [7:0] errcount;
    logic [3:0] first_err_idx, vec_idx;
    logic       busy3, done3, pass3;
    logic [2:0] errcount3;
    logic [3:0] first_err_idx3, vec_idx3;

    logic [NV-1:0] err_vec = '0;

    // Identity DUV with selectable corrupted vectors; second DUV always wrong.
    assign dif0.duv_resp = dif0.stim ^ (err_vec[vec_idx] ? 8'h01 : 8'h00);
    assign dif0.exp_resp = dif0.stim;
    assign dif3.duv_resp = ~dif3.stim;
    assign dif3.exp_resp = dif3.stim;

    bist_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .duv           (dif0),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .errcount      (errcount),
        .first_err_idx (first_err_idx),
        .vec_idx       (vec_idx)
    );

    bist_ctrl #(.ERR_W(3)) u_dut3 (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .duv           (dif3),
        .busy          (busy3),
        .done          (done3),
        .pass          (pass3),
        .errcount      (errcount3),
        .first_err_idx (first_err_idx3),
        .vec_idx       (vec_idx3)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_stim = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && dif0.stim_valid) begin
            last_stim = dif0.stim;
            if (exp_q.size() == 0) begin
                chk("stim_unexp", 32'(dif0.stim), 32'hFFFF_FFFF);
            end else begin
                chk("stim", 32'(dif0.stim), 32'(exp_q.pop_front()));
            end
        end else if (rst && busy && !dif0.duv_rst) begin
            chk("stim_hold", 32'(dif0.stim), 32'(last_stim));
        end
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_duv_rst"}, 32'(dif0.duv_rst), 1);
        chk({pfx, "_stim"}, 32'(dif0.stim), 0);
        chk({pfx, "_stim_valid"}, 32'(dif0.stim_valid), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_pass"}, 32'(pass), 0);
        chk({pfx, "_errcount"}, 32'(errcount), 0);
        chk({pfx, "_first_err"}, 32'(first_err_idx), 0);
        chk({pfx, "_vec_idx"}, 32'(vec_idx), 0);
    endtask

    // Pulses start, queues the expected stimulus sequence; returns at the negedge after the start edge.
    task automatic kick();
        for (int i = 0; i < NV; i++) exp_q.push_back(8'(TB_SEED + 8'(i)));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done(input int pulse_cyc, output int rst_cnt);
        rst_cnt = 0;
        while (!done && cyc < 300) begin
            if (dif0.duv_rst) rst_cnt++;
            start = (cyc == pulse_cyc);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int rc;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_duv_rst", 32'(dif0.duv_rst), 0);
        chk("rel_busy", 32'(busy), 0);

        // Clean identity run
        err_vec = '0;
        kick();
        chk("run1_busy", 32'(busy), 1);
        wait_done(-1, rc);
        chk("run1_len", cyc, RUN_LEN);
        chk("run1_rstd_len", rc, 2);
        chk("run1_done", 32'(done), 1);
        chk("run1_pass", 32'(pass), 1);
        chk("run1_err", 32'(errcount), 0);
        chk("run1_busy_end", 32'(busy), 0);
        chk("run1_vec_last", 32'(vec_idx), NV - 1);
        chk("run1_q_empty", exp_q.size(), 0);
        chk("sat_err", 32'(errcount3), 7);
        chk("sat_ferr", 32'(first_err_idx3), 0);
        chk("sat_pass", 32'(pass3), 0);
        chk("sat_done", 32'(done3), 1);
        repeat (3) @(negedge clk);
        chk("run1_done_held", 32'(done), 1);

        // Mismatches at vectors 5 and 9
        err_vec = '0;
        err_vec[5] = 1'b1;
        err_vec[9] = 1'b1;
        kick();
        wait_done(-1, rc);
        chk("mm_len", cyc, RUN_LEN);
        chk("mm_err", 32'(errcount), 2);
        chk("mm_ferr", 32'(first_err_idx), 5);
        chk("mm_pass", 32'(pass), 0);
        chk("mm_done", 32'(done), 1);

        // start pulsed during WAIT of vector 0 is ignored; start from DONE clears results
        err_vec = '0;
        kick();
        wait_done(3, rc);
        chk("wstart_len", cyc, RUN_LEN);
        chk("wstart_pass", 32'(pass), 1);
        chk("wstart_err", 32'(errcount), 0);
        chk("wstart_ferr", 32'(first_err_idx), 0);

        // Abort during CHECK of vector 3 (mismatch earlier at vector 1)
        err_vec = '0;
        err_vec[1] = 1'b1;
        kick();
        step_to(17);
        chk("ab_at_vec", 32'(vec_idx), 3);
        chk("ab_busy_pre", 32'(busy), 1);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_err", 32'(errcount), 1);
        chk("ab_stim_valid", 32'(dif0.stim_valid), 0);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle_busy", 32'(busy), 0);
        chk("ab_idle_err", 32'(errcount), 1);

        // Reset asserted mid-run during vector 7
        err_vec = '0;
        kick();
        step_to(31);
        chk("mrst_at_vec", 32'(vec_idx), 7);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("mrst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_rel_duv_rst", 32'(dif0.duv_rst), 0);
        kick();
        wait_done(-1, rc);
        chk("mrst_run_len", cyc, RUN_LEN);
        chk("mrst_run_pass", 32'(pass), 1);
        chk("mrst_run_err", 32'(errcount), 0);
        chk("mrst_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
